gshare_ctrl: RTL and testbench

GSHARE_CTRL -- requirements
Module: gshare_ctrl

---
 rtl/gshare_ctrl.sv | 161 ++++++++++++++++
 tb/tb_gshare_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_ctrl.sv
// gshare_ctrl: gshare branch direction predictor controller.
//
// Owns the speculative global history register, forms the gshare index
// (PC xor history) for an external counter table, and schedules the
// counter updates for resolved branches. After reset it initialises every
// table entry to INIT_VAL before it starts predicting.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   fetch_valid/_pc     prediction request from fetch
//   pred_*              prediction result, carried down the pipe with the branch
//   init_busy           table initialisation in progress (fetch stalls)
//   bht_rindex/rdata    combinational read port of the counter table
//   bht_load/windex/    write port of the counter table
//   bht_wdata
//   res_*               branch resolution from EX, with the carried pred_* values
//   stat_branches       resolved-branch count (wraps)
//   stat_mispredicts    mispredict count (wraps)
//
// Handshake: fetch_valid and res_valid are single-cycle qualifiers with no
// backpressure; a request is consumed in the cycle it is asserted, unless
// init_busy is high, in which case it is ignored.
module gshare_ctrl #(
    parameter int S_INDEX   = 10,
    parameter int HIST_LEN  = 10,
    parameter int CNT_WIDTH = 2,
    parameter logic [CNT_WIDTH-1:0] INIT_VAL = CNT_WIDTH'(1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_pc,
    output logic                 pred_taken,
    output logic [S_INDEX-1:0]   pred_index,
    output logic [HIST_LEN-1:0]  pred_ghr,
    output logic [CNT_WIDTH-1:0] pred_cnt,
    output logic                 init_busy,
    output logic [S_INDEX-1:0]   bht_rindex,
    input  logic [CNT_WIDTH-1:0] bht_rdata,
    output logic                 bht_load,
    output logic [S_INDEX-1:0]   bht_windex,
    output logic [CNT_WIDTH-1:0] bht_wdata,
    input  logic                 res_valid,
    input  logic                 res_taken,
    input  logic                 res_mispredict,
    input  logic [S_INDEX-1:0]   res_index,
    input  logic [CNT_WIDTH-1:0] res_cnt,
    input  logic [HIST_LEN-1:0]  res_ghr,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [S_INDEX-1:0]     init_cnt;
    logic [HIST_LEN-1:0]    ghr;
    logic                   upd_valid;
    logic [S_INDEX-1:0]     upd_index;
    logic [CNT_WIDTH-1:0]   upd_data;
    logic [S_INDEX-1:0]     ghr_ext;
    logic                   unused_pc;

    // Saturating counter step: never wraps at either bound.
    function automatic logic [CNT_WIDTH-1:0] sat(input logic [CNT_WIDTH-1:0] c,
                                                 input logic t);
        if (t) begin
            return (c == '1) ? c : c + 1'b1;
        end else begin
            return (c == '0) ? c : c - 1'b1;
        end
    endfunction

    // Shift a new outcome into bit 0, dropping the oldest bit. Written as a
    // loop so it also elaborates for HIST_LEN == 1.
    function automatic logic [HIST_LEN-1:0] shift_in(input logic [HIST_LEN-1:0] h,
                                                     input logic b);
        logic [HIST_LEN-1:0] n;
        n = '0;
        for (int i = HIST_LEN - 1; i > 0; i--) begin
            n[i] = h[i-1];
        end
        n[0] = b;
        return n;
    endfunction

    // Only the word-index bits of the PC participate in the hash.
    assign unused_pc = ^{fetch_pc[31:S_INDEX+2], fetch_pc[1:0]};

    always_comb begin
        ghr_ext = '0;
        ghr_ext[HIST_LEN-1:0] = ghr;
    end

    assign pred_index = fetch_pc[S_INDEX+1:2] ^ ghr_ext;
    assign bht_rindex = pred_index;
    assign pred_cnt   = bht_rdata;
    assign pred_ghr   = ghr;
    assign pred_taken = (state == ST_RUN) ? bht_rdata[CNT_WIDTH-1] : 1'b0;
    assign init_busy  = (state == ST_INIT);

    // Init writes come straight from the init counter so the first entry is
    // written in the very first cycle after reset release. They are gated
    // by rst so the write port is quiet while reset is held.
    always_comb begin
        bht_load   = upd_valid;
        bht_windex = upd_index;
        bht_wdata  = upd_data;
        if (state == ST_INIT) begin
            bht_load   = ~rst;
            bht_windex = init_cnt;
            bht_wdata  = rst ? '0 : INIT_VAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_INIT;
            init_cnt         <= '0;
            ghr              <= '0;
            upd_valid        <= 1'b0;
            upd_index        <= '0;
            upd_data         <= '0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    upd_valid <= 1'b0;
                    init_cnt  <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Update uses the counter value carried with the branch,
                    // so back-to-back resolves never depend on a re-read.
                    upd_valid <= res_valid;
                    if (res_valid) begin
                        upd_index     <= res_index;
                        upd_data      <= sat(res_cnt, res_taken);
                        stat_branches <= stat_branches + 32'd1;
                    end
                    // A mispredict repairs history from the branch's own
                    // snapshot and discards any same-cycle speculative shift.
                    if (res_valid && res_mispredict) begin
                        ghr              <= shift_in(res_ghr, res_taken);
                        stat_mispredicts <= stat_mispredicts + 32'd1;
                    end else if (fetch_valid) begin
                        ghr <= shift_in(ghr, pred_taken);
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_ctrl.sv
// Testbench for gshare_ctrl with S_INDEX=4, HIST_LEN=4, CNT_WIDTH=2.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// The counter table is modelled here as a 16-entry array with write-data
// bypass onto the read port.
module tb_gshare_ctrl;

    localparam int SI = 4;
    localparam int HL = 4;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          fetch_valid;
    logic [31:0]   fetch_pc;
    logic          pred_taken;
    logic [SI-1:0] pred_index;
    logic [HL-1:0] pred_ghr;
    logic [CW-1:0] pred_cnt;
    logic          init_busy;
    logic [SI-1:0] bht_rindex;
    logic [CW-1:0] bht_rdata;
    logic          bht_load;
    logic [SI-1:0] bht_windex;
    logic [CW-1:0] bht_wdata;
    logic          res_valid;
    logic          res_taken;
    logic          res_mispredict;
    logic [SI-1:0] res_index;
    logic [CW-1:0] res_cnt;
    logic [HL-1:0] res_ghr;
    logic [31:0]   stat_branches;
    logic [31:0]   stat_mispredicts;

    gshare_ctrl #(
        .S_INDEX  (SI),
        .HIST_LEN (HL),
        .CNT_WIDTH(CW),
        .INIT_VAL (2'b01)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_index      (pred_index),
        .pred_ghr        (pred_ghr),
        .pred_cnt        (pred_cnt),
        .init_busy       (init_busy),
        .bht_rindex      (bht_rindex),
        .bht_rdata       (bht_rdata),
        .bht_load        (bht_load),
        .bht_windex      (bht_windex),
        .bht_wdata       (bht_wdata),
        .res_valid       (res_valid),
        .res_taken       (res_taken),
        .res_mispredict  (res_mispredict),
        .res_index       (res_index),
        .res_cnt         (res_cnt),
        .res_ghr         (res_ghr),
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counter table ----------------
    logic [CW-1:0] mem [16];

    always_comb begin
        bht_rdata = mem[bht_rindex];
        if (bht_load && bht_windex == bht_rindex) bht_rdata = bht_wdata;
    end

    always @(posedge clk) begin
        if (bht_load) mem[bht_windex] <= bht_wdata;
    end

    // ---------------- scoreboard / reference model ----------------
    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [3:0]  exp_ghr;
    logic [31:0] exp_br;
    logic [31:0] exp_mi;
    // Expected table writes from resolved branches; at most one is due per cycle.
    logic [CW+SI-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c, input logic t);
        int v;
        v = int'(c);
        if (t) v = (v < 3) ? v + 1 : 3;
        else   v = (v > 0) ? v - 1 : 0;
        return CW'(v);
    endfunction

    task automatic model_reset();
        exp_ghr = '0;
        exp_br  = '0;
        exp_mi  = '0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        fetch_valid    = 1'b0;
        fetch_pc       = '0;
        res_valid      = 1'b0;
        res_taken      = 1'b0;
        res_mispredict = 1'b0;
        res_index      = '0;
        res_cnt        = '0;
        res_ghr        = '0;
    endtask

    task automatic drive_random();
        fetch_valid    = 1'($urandom_range(0, 1));
        fetch_pc       = $urandom;
        res_valid      = 1'($urandom_range(0, 1));
        res_taken      = 1'($urandom_range(0, 1));
        res_mispredict = ($urandom_range(0, 2) == 0);
        res_index      = 4'($urandom_range(0, 15));
        res_cnt        = 2'($urandom_range(0, 3));
        res_ghr        = 4'($urandom_range(0, 15));
    endtask

    // One RUN-mode cycle: drive, check outputs against the model, advance model.
    task automatic step(input logic fv, input logic [31:0] pc, input logic rv,
                        input logic rt, input logic rm, input logic [3:0] ri,
                        input logic [1:0] rc, input logic [3:0] rg);
        logic [3:0]       idx;
        logic [1:0]       rd;
        logic [CW+SI-1:0] w;
        @(negedge clk);
        fetch_valid = fv; fetch_pc = pc; res_valid = rv; res_taken = rt;
        res_mispredict = rm; res_index = ri; res_cnt = rc; res_ghr = rg;
        #1;
        idx = pc[5:2] ^ exp_ghr;
        rd  = mem[idx];
        if (exp_q.size() != 0 && exp_q[0][SI-1:0] == idx) rd = exp_q[0][CW+SI-1:SI];
        chk("init_busy_run", 32'(init_busy), 32'(1'b0));
        chk("pred_index", 32'(pred_index), 32'(idx));
        chk("pred_taken", 32'(pred_taken), 32'(rd[1]));
        chk("pred_cnt", 32'(pred_cnt), 32'(rd));
        chk("pred_ghr", 32'(pred_ghr), 32'(exp_ghr));
        chk("bht_load", 32'(bht_load), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("bht_windex", 32'(bht_windex), 32'(w[SI-1:0]));
            chk("bht_wdata", 32'(bht_wdata), 32'(w[CW+SI-1:SI]));
        end
        chk("stat_branches", stat_branches, exp_br);
        chk("stat_mispredicts", stat_mispredicts, exp_mi);
        if (rv) begin
            exp_br = exp_br + 1;
            exp_q.push_back({next_cnt(rc, rt), ri});
            if (rm) exp_mi = exp_mi + 1;
        end
        if (rv && rm) exp_ghr = {rg[2:0], rt};
        else if (fv)  exp_ghr = {exp_ghr[2:0], rd[1]};
    endtask

    // Assert reset on a falling edge and check the held-reset outputs.
    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        drive_random();
        #1;
        chk("rst_init_busy", 32'(init_busy), 32'(1'b1));
        chk("rst_bht_load", 32'(bht_load), 32'(1'b0));
        chk("rst_bht_windex", 32'(bht_windex), 32'(0));
        chk("rst_bht_wdata", 32'(bht_wdata), 32'(0));
        chk("rst_pred_taken", 32'(pred_taken), 32'(1'b0));
        chk("rst_pred_ghr", 32'(pred_ghr), 32'(0));
        chk("rst_stat_br", stat_branches, 32'(0));
        chk("rst_stat_mi", stat_mispredicts, 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Check n init cycles starting right after a release on a falling edge.
    // Fetch/resolve inputs are randomised to show they are ignored.
    task automatic init_check(input int n);
        for (int i = 0; i < n; i++) begin
            drive_random();
            #1;
            chk("init_busy", 32'(init_busy), 32'(1'b1));
            chk("init_load", 32'(bht_load), 32'(1'b1));
            chk("init_windex", 32'(bht_windex), 32'(i));
            chk("init_wdata", 32'(bht_wdata), 32'(2'b01));
            chk("init_pred_taken", 32'(pred_taken), 32'(1'b0));
            chk("init_ghr", 32'(pred_ghr), 32'(0));
            chk("init_stat_br", stat_branches, 32'(0));
            @(negedge clk);
        end
    endtask

    task automatic init_done_check();
        drive_idle();
        #1;
        chk("post_init_busy", 32'(init_busy), 32'(1'b0));
        chk("post_init_load", 32'(bht_load), 32'(1'b0));
        chk("post_init_ghr", 32'(pred_ghr), 32'(0));
        chk("post_init_stat_mi", stat_mispredicts, 32'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [31:0] br0, mi0;

    initial begin
        rst = 1'b1;
        drive_idle();
        for (int i = 0; i < 16; i++) mem[i] = 2'b10;
        model_reset();

        // Reset and full initialisation
        reset_pulse();
        init_check(16);
        init_done_check();

        // Make entry 5 strongly taken without touching history
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd5, 2'b10, 4'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 4'h0);

        // ghr=0, pc=0x14, entry 5 = 11 -> index 5, taken, then ghr=0001
        step(1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 4'h0);
        chk("d_pred_index", 32'(pred_index), 32'd5);
        chk("d_pred_taken", 32'(pred_taken), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 4'h0);
        chk("d_ghr_0001", 32'(pred_ghr), 32'b0001);

        // Saturating updates at both bounds, 1-cycle latency
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd3, 2'b11, 4'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 4'h0);
        chk("d_upd_load", 32'(bht_load), 32'd1);
        chk("d_upd_windex", 32'(bht_windex), 32'd3);
        chk("d_upd_wdata_hi", 32'(bht_wdata), 32'b11);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'd3, 2'b00, 4'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 4'h0);
        chk("d_upd_wdata_lo", 32'(bht_wdata), 32'b00);

        // Mispredict repair wins over a same-cycle taken fetch.
        // ghr=0001, pc[5:2]=4 -> index 5 (strongly taken).
        br0 = stat_branches;
        mi0 = stat_mispredicts;
        step(1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 4'd7, 2'b01, 4'b1010);
        chk("d_mis_pred_taken", 32'(pred_taken), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 4'h0);
        chk("d_mis_ghr", 32'(pred_ghr), 32'b0100);
        chk("d_mis_stat_mi", stat_mispredicts, mi0 + 32'd1);
        chk("d_mis_stat_br", stat_branches, br0 + 32'd1);

        // Randomised RUN traffic
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));
        end

        // Reset in RUN with an update pending: it must be dropped
        step(1'b1, 32'h0000_0044, 1'b1, 1'b1, 1'b1, 4'd9, 2'b01, 4'b0110);
        reset_pulse();
        init_check(16);
        init_done_check();
        for (int n = 0; n < 100; n++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));
        end

        // Reset in the middle of initialisation restarts at index 0
        reset_pulse();
        init_check(6);
        reset_pulse();
        init_check(16);
        init_done_check();
        for (int n = 0; n < 100; n++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
